// File: rtl/tmds_pkg.sv
// Shared definitions for the HDMI TMDS lane encoder.
//   MODE_*      : 3-bit lane mode codes driven by the frame/packet scheduler
//   CTRL_TOKEN  : control-period symbols indexed by {C1,C0}
//   GB_VIDEO    : video guard-band symbol per lane
//   GB_DATA     : data-island guard-band symbol on lanes 1/2
//   terc4_f     : TERC4 nibble-to-symbol map
//   popcount8   : number of ones in a byte
package tmds_pkg;

  localparam logic [2:0] MODE_CTRL  = 3'b000;
  localparam logic [2:0] MODE_VIDEO = 3'b001;
  localparam logic [2:0] MODE_TERC4 = 3'b010;
  localparam logic [2:0] MODE_VGB   = 3'b011;
  localparam logic [2:0] MODE_DGB   = 3'b100;

  localparam logic [9:0] CTRL_TOKEN [0:3] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
  localparam logic [9:0] GB_VIDEO   [0:2] = '{10'h2CC, 10'h133, 10'h2CC};
  localparam logic [9:0] GB_DATA          = 10'h133;

  function automatic logic [9:0] terc4_f(input logic [3:0] nib);
    logic [9:0] sym;
    case (nib)
      4'h0: sym = 10'h29C;
      4'h1: sym = 10'h263;
      4'h2: sym = 10'h2E4;
      4'h3: sym = 10'h2E2;
      4'h4: sym = 10'h171;
      4'h5: sym = 10'h11E;
      4'h6: sym = 10'h18E;
      4'h7: sym = 10'h13C;
      4'h8: sym = 10'h2CC;
      4'h9: sym = 10'h139;
      4'hA: sym = 10'h19C;
      4'hB: sym = 10'h2C7;
      4'hC: sym = 10'h28E;
      4'hD: sym = 10'h271;
      4'hE: sym = 10'h163;
      default: sym = 10'h2C3;
    endcase
    return sym;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// First two pipeline stages of the TMDS video path: transition-minimised
// byte q_m[8:0] plus its ones/zeros count.
//   i_clk, i_rst_n : pixel clock, async active-low reset
//   i_ce           : clock enable (0 holds every register)
//   i_din          : video byte
//   o_qm           : q_m[8:0], two enabled cycles after i_din
//   o_n1, o_n0     : ones / zeros in o_qm[7:0]
module tmds_qm_stage
  import tmds_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ce,
  input  logic [7:0] i_din,
  output logic [8:0] o_qm,
  output logic [3:0] o_n1,
  output logic [3:0] o_n0
);

  logic [7:0] r_din_p1;
  logic [3:0] r_n1d_p1;
  logic       w_use_xnor;
  logic [8:0] w_qm;
  logic [3:0] w_n1_qm;
  logic [8:0] r_qm_p2;
  logic [3:0] r_n1_p2;
  logic [3:0] r_n0_p2;

  // S1: register byte and its popcount
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_din_p1 <= '0;
      r_n1d_p1 <= '0;
    end else if (i_ce) begin
      r_din_p1 <= i_din;
      r_n1d_p1 <= popcount8(i_din);
    end
  end

  // XNOR chain when the byte is ones-heavy (ties broken by bit 0) to cut transitions.
  always_comb begin
    w_use_xnor = (r_n1d_p1 > 4'd4) || ((r_n1d_p1 == 4'd4) && !r_din_p1[0]);
    w_qm       = '0;
    w_qm[0]    = r_din_p1[0];
    for (int i = 1; i < 8; i++) begin
      w_qm[i] = w_use_xnor ? ~(w_qm[i-1] ^ r_din_p1[i]) : (w_qm[i-1] ^ r_din_p1[i]);
    end
    w_qm[8] = ~w_use_xnor;
  end

  assign w_n1_qm = popcount8(w_qm[7:0]);

  // S2: register q_m and its balance counts
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_qm_p2 <= '0;
      r_n1_p2 <= '0;
      r_n0_p2 <= '0;
    end else if (i_ce) begin
      r_qm_p2 <= w_qm;
      r_n1_p2 <= w_n1_qm;
      r_n0_p2 <= 4'd8 - w_n1_qm;
    end
  end

  assign o_qm = r_qm_p2;
  assign o_n1 = r_n1_p2;
  assign o_n0 = r_n0_p2;

endmodule

// File: rtl/tmds_hdmi_encoder.sv
// Per-lane HDMI TMDS encoder: video (DC-balanced 8b/10b), control tokens,
// TERC4 data-island symbols and guard bands.
// Latency 3 enabled cycles input -> Dout (4 with OUT_REG=1).
//   Clk, RstB   : pixel clock, async active-low reset
//   Ce          : clock enable; 0 freezes all state
//   Mode        : 000 ctrl, 001 video, 010 TERC4, 011 video GB, 100 data-island GB
//   Din         : video byte; C0/C1 : control bits; Aux : TERC4 nibble
//   Dout        : 10-bit symbol, bit 0 sent first
//   Disparity   : running disparity, two's complement, monitor only
module tmds_hdmi_encoder
  import tmds_pkg::*;
#(
  parameter int CHAN    = 0,
  parameter int CNT_W   = 5,
  parameter int OUT_REG = 0
) (
  input  logic             Clk,
  input  logic             RstB,
  input  logic             Ce,
  input  logic [2:0]       Mode,
  input  logic [7:0]       Din,
  input  logic             C0,
  input  logic             C1,
  input  logic [3:0]       Aux,
  output logic [9:0]       Dout,
  output logic [CNT_W-1:0] Disparity
);

  localparam logic [9:0] GB_VID_SYM = (CHAN == 1) ? GB_VIDEO[1] :
                                      ((CHAN == 2) ? GB_VIDEO[2] : GB_VIDEO[0]);
  localparam logic       IS_CHAN0   = (CHAN == 0);
  localparam logic signed [CNT_W-1:0] TWO = {{(CNT_W-2){1'b0}}, 2'b10};

  logic [2:0] r_mode_p1, r_mode_p2;
  logic [1:0] r_c_p1,    r_c_p2;
  logic [3:0] r_aux_p1,  r_aux_p2;

  logic [8:0] w_qm_p2;
  logic [3:0] w_n1_p2;
  logic [3:0] w_n0_p2;

  logic signed [CNT_W-1:0] w_n1s, w_n0s, w_diff;
  logic signed [CNT_W-1:0] w_cnt_nxt;
  logic signed [CNT_W-1:0] r_cnt_p3;
  logic                    w_cnt_pos, w_cnt_neg;
  logic [9:0]              w_sym;
  logic [9:0]              r_dout_p3;

  tmds_qm_stage u_qm (
    .i_clk   (Clk),
    .i_rst_n (RstB),
    .i_ce    (Ce),
    .i_din   (Din),
    .o_qm    (w_qm_p2),
    .o_n1    (w_n1_p2),
    .o_n0    (w_n0_p2)
  );

  // S1/S2: side-band delay matching the q_m stage
  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      r_mode_p1 <= '0;
      r_c_p1    <= '0;
      r_aux_p1  <= '0;
      r_mode_p2 <= '0;
      r_c_p2    <= '0;
      r_aux_p2  <= '0;
    end else if (Ce) begin
      r_mode_p1 <= Mode;
      r_c_p1    <= {C1, C0};
      r_aux_p1  <= Aux;
      r_mode_p2 <= r_mode_p1;
      r_c_p2    <= r_c_p1;
      r_aux_p2  <= r_aux_p1;
    end
  end

  assign w_n1s     = {{(CNT_W-4){1'b0}}, w_n1_p2};
  assign w_n0s     = {{(CNT_W-4){1'b0}}, w_n0_p2};
  assign w_diff    = w_n1s - w_n0s;
  assign w_cnt_neg = r_cnt_p3[CNT_W-1];
  assign w_cnt_pos = !r_cnt_p3[CNT_W-1] && (r_cnt_p3 != '0);

  // Symbol select; any mode other than video zeroes the disparity.
  always_comb begin
    w_sym     = CTRL_TOKEN[r_c_p2];
    w_cnt_nxt = '0;
    case (r_mode_p2)
      MODE_CTRL: w_sym = CTRL_TOKEN[r_c_p2];
      MODE_VIDEO: begin
        if ((r_cnt_p3 == '0) || (w_n1_p2 == w_n0_p2)) begin
          w_sym     = {~w_qm_p2[8], w_qm_p2[8], w_qm_p2[8] ? w_qm_p2[7:0] : ~w_qm_p2[7:0]};
          w_cnt_nxt = w_qm_p2[8] ? (r_cnt_p3 + w_diff) : (r_cnt_p3 - w_diff);
        end else if ((w_cnt_pos && (w_n1_p2 > w_n0_p2)) ||
                     (w_cnt_neg && (w_n0_p2 > w_n1_p2))) begin
          w_sym     = {1'b1, w_qm_p2[8], ~w_qm_p2[7:0]};
          w_cnt_nxt = r_cnt_p3 + (w_qm_p2[8] ? TWO : '0) - w_diff;
        end else begin
          w_sym     = {1'b0, w_qm_p2[8], w_qm_p2[7:0]};
          w_cnt_nxt = r_cnt_p3 + w_diff - (w_qm_p2[8] ? '0 : TWO);
        end
      end
      MODE_TERC4: w_sym = terc4_f(r_aux_p2);
      MODE_VGB:   w_sym = GB_VID_SYM;
      MODE_DGB:   w_sym = IS_CHAN0 ? terc4_f(r_aux_p2) : GB_DATA;
      default:    w_sym = CTRL_TOKEN[r_c_p2];
    endcase
  end

  // S3: symbol and running disparity
  always_ff @(posedge Clk or negedge RstB) begin
    if (!RstB) begin
      r_dout_p3 <= '0;
      r_cnt_p3  <= '0;
    end else if (Ce) begin
      r_dout_p3 <= w_sym;
      r_cnt_p3  <= w_cnt_nxt;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [9:0]       r_dout_p4;
      logic [CNT_W-1:0] r_disp_p4;

      // S4: optional retiming register toward the serialiser
      always_ff @(posedge Clk or negedge RstB) begin
        if (!RstB) begin
          r_dout_p4 <= '0;
          r_disp_p4 <= '0;
        end else if (Ce) begin
          r_dout_p4 <= r_dout_p3;
          r_disp_p4 <= r_cnt_p3;
        end
      end

      assign Dout      = r_dout_p4;
      assign Disparity = r_disp_p4;
    end else begin : g_no_out_reg
      assign Dout      = r_dout_p3;
      assign Disparity = r_cnt_p3;
    end
  endgenerate

endmodule

// File: tb/tb_tmds_hdmi_encoder.sv
// Bench for tmds_hdmi_encoder: CHAN0 (main), CHAN1, and CHAN0 with OUT_REG=1.
module tb_tmds_hdmi_encoder;

  logic       Clk = 1'b0;
  logic       RstB;
  logic       Ce;
  logic [2:0] Mode;
  logic [7:0] Din;
  logic       C0, C1;
  logic [3:0] Aux;

  logic [9:0] dout0, dout1, douto;
  logic [4:0] disp0, disp1, dispo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
  } exp_t;

  exp_t hist[$];
  int   m_cnt;

  always #5 Clk = ~Clk;

  tmds_hdmi_encoder #(.CHAN(0), .CNT_W(5), .OUT_REG(0)) dut0 (
    .Clk(Clk), .RstB(RstB), .Ce(Ce), .Mode(Mode), .Din(Din), .C0(C0), .C1(C1),
    .Aux(Aux), .Dout(dout0), .Disparity(disp0));

  tmds_hdmi_encoder #(.CHAN(1), .CNT_W(5), .OUT_REG(0)) dut1 (
    .Clk(Clk), .RstB(RstB), .Ce(Ce), .Mode(Mode), .Din(Din), .C0(C0), .C1(C1),
    .Aux(Aux), .Dout(dout1), .Disparity(disp1));

  tmds_hdmi_encoder #(.CHAN(0), .CNT_W(5), .OUT_REG(1)) duto (
    .Clk(Clk), .RstB(RstB), .Ce(Ce), .Mode(Mode), .Din(Din), .C0(C0), .C1(C1),
    .Aux(Aux), .Dout(douto), .Disparity(dispo));

  function automatic logic [9:0] terc4_ref(input logic [3:0] a);
    case (a)
      4'h0: return 10'h29C;  4'h1: return 10'h263;  4'h2: return 10'h2E4;  4'h3: return 10'h2E2;
      4'h4: return 10'h171;  4'h5: return 10'h11E;  4'h6: return 10'h18E;  4'h7: return 10'h13C;
      4'h8: return 10'h2CC;  4'h9: return 10'h139;  4'hA: return 10'h19C;  4'hB: return 10'h2C7;
      4'hC: return 10'h28E;  4'hD: return 10'h271;  4'hE: return 10'h163;  default: return 10'h2C3;
    endcase
  endfunction

  // Reference encoder for lane 0, applied to each input accepted on an enabled edge.
  task automatic model_push(input logic [2:0] md, input logic [7:0] d,
                            input logic c1, input logic c0, input logic [3:0] a);
    logic [9:0] sym;
    logic [8:0] qm;
    logic       xn;
    int         n1d, n1, n0;
    exp_t       e;
    if (md == 3'b001) begin
      n1d = $countones(d);
      xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~xn;
      n1 = $countones(qm[7:0]);
      n0 = 8 - n1;
      if (m_cnt == 0 || n1 == n0) begin
        sym   = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
        m_cnt = m_cnt + (qm[8] ? (n1 - n0) : (n0 - n1));
      end else if ((m_cnt > 0 && n1 > n0) || (m_cnt < 0 && n0 > n1)) begin
        sym   = {1'b1, qm[8], ~qm[7:0]};
        m_cnt = m_cnt + (qm[8] ? 2 : 0) + n0 - n1;
      end else begin
        sym   = {1'b0, qm[8], qm[7:0]};
        m_cnt = m_cnt + n1 - n0 - (qm[8] ? 0 : 2);
      end
    end else begin
      m_cnt = 0;
      case (md)
        3'b010:  sym = terc4_ref(a);
        3'b011:  sym = 10'h2CC;
        3'b100:  sym = terc4_ref(a);
        default: case ({c1, c0})
                   2'b00:   sym = 10'h354;
                   2'b01:   sym = 10'h0AB;
                   2'b10:   sym = 10'h154;
                   default: sym = 10'h2AB;
                 endcase
      endcase
    end
    e.sym = sym;
    e.cnt = m_cnt;
    hist.push_back(e);
  endtask

  always @(posedge Clk) begin
    if (RstB === 1'b1 && Ce === 1'b1) model_push(Mode, Din, C1, C0, Aux);
  end

  // Cleared pipeline holds two control-00 entries ahead of the first input.
  task automatic model_reset();
    exp_t e;
    hist.delete();
    m_cnt = 0;
    e.sym = 10'h354;
    e.cnt = 0;
    hist.push_back(e);
    hist.push_back(e);
  endtask

  task automatic test_reset();
    logic [9:0] exp0 [4];
    logic [9:0] expo [4];
    exp0 = '{10'h354, 10'h354, 10'h0AB, 10'h0AB};
    expo = '{10'h000, 10'h354, 10'h354, 10'h0AB};
    @(negedge Clk);
    RstB = 1'b0; Ce = 1'b1; Mode = 3'b000; C1 = 1'b0; C0 = 1'b1; Din = 8'h00; Aux = 4'h0;
    model_reset();
    #1;
    total++; if (dout0 !== 10'h000) begin bad++; $display("FAIL reset_dout0 got=%h want=000", dout0); end
    total++; if (douto !== 10'h000) begin bad++; $display("FAIL reset_douto got=%h want=000", douto); end
    total++; if (disp0 !== 5'h00) begin bad++; $display("FAIL reset_disp0 got=%h want=00", disp0); end
    @(negedge Clk);
    total++; if (dout0 !== 10'h000) begin bad++; $display("FAIL reset_hold_dout0 got=%h want=000", dout0); end
    RstB = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clk);
      total++; if (dout0 !== exp0[k]) begin bad++; $display("FAIL ctrl_seq_dout0 edge=%0d got=%h want=%h", k+1, dout0, exp0[k]); end
      total++; if (douto !== expo[k]) begin bad++; $display("FAIL ctrl_seq_douto edge=%0d got=%h want=%h", k+1, douto, expo[k]); end
      total++; if (disp0 !== 5'h00) begin bad++; $display("FAIL ctrl_seq_disp0 edge=%0d got=%h want=00", k+1, disp0); end
    end
  endtask

  task automatic test_video_zero();
    @(negedge Clk); Mode = 3'b001; Din = 8'h00;
    @(negedge Clk);
    @(negedge Clk); Mode = 3'b000; C1 = 1'b0; C0 = 1'b0;
    @(negedge Clk);
    total++; if (dout0 !== 10'h100) begin bad++; $display("FAIL video0_first got=%h want=100", dout0); end
    total++; if (disp0 !== 5'h18) begin bad++; $display("FAIL video0_first_disp got=%h want=18", disp0); end
    @(negedge Clk);
    total++; if (dout0 !== 10'h3FF) begin bad++; $display("FAIL video0_second got=%h want=3ff", dout0); end
    total++; if (disp0 !== 5'h02) begin bad++; $display("FAIL video0_second_disp got=%h want=02", disp0); end
    @(negedge Clk);
    total++; if (dout0 !== 10'h354) begin bad++; $display("FAIL video0_back_ctrl got=%h want=354", dout0); end
    total++; if (disp0 !== 5'h00) begin bad++; $display("FAIL video0_ctrl_disp got=%h want=00", disp0); end
  endtask

  task automatic test_terc4();
    logic [9:0] tbl [16];
    tbl = '{10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
            10'h2CC, 10'h139, 10'h19C, 10'h2C7, 10'h28E, 10'h271, 10'h163, 10'h2C3};
    for (int i = 0; i < 19; i++) begin
      @(negedge Clk);
      if (i >= 3) begin
        total++; if (dout0 !== tbl[i-3]) begin bad++; $display("FAIL terc4_ch0 aux=%0d got=%h want=%h", i-3, dout0, tbl[i-3]); end
        total++; if (dout1 !== tbl[i-3]) begin bad++; $display("FAIL terc4_ch1 aux=%0d got=%h want=%h", i-3, dout1, tbl[i-3]); end
        total++; if (disp0 !== 5'h00) begin bad++; $display("FAIL terc4_disp aux=%0d got=%h want=00", i-3, disp0); end
      end
      if (i < 16) begin
        Mode = 3'b010; Aux = 4'(i);
      end else begin
        Mode = 3'b000;
      end
    end
  endtask

  task automatic test_guard();
    @(negedge Clk); Mode = 3'b011;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    total++; if (dout0 !== 10'h2CC) begin bad++; $display("FAIL vgb_ch0 got=%h want=2cc", dout0); end
    total++; if (dout1 !== 10'h133) begin bad++; $display("FAIL vgb_ch1 got=%h want=133", dout1); end
    Mode = 3'b100; Aux = 4'hC;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    total++; if (dout0 !== 10'h28E) begin bad++; $display("FAIL dgb_ch0 got=%h want=28e", dout0); end
    total++; if (dout1 !== 10'h133) begin bad++; $display("FAIL dgb_ch1 got=%h want=133", dout1); end
    total++; if (disp1 !== 5'h00) begin bad++; $display("FAIL dgb_disp1 got=%h want=00", disp1); end
  endtask

  task automatic test_ce_freeze();
    exp_t e0, eo;
    for (int i = 0; i < 30; i++) begin
      @(negedge Clk);
      e0.sym = 10'h000; e0.cnt = 0;
      eo.sym = 10'h000; eo.cnt = 0;
      if (hist.size() >= 3) e0 = hist[hist.size()-3];
      if (hist.size() >= 4) eo = hist[hist.size()-4];
      total++; if (dout0 !== e0.sym) begin bad++; $display("FAIL ce_dout0 i=%0d got=%h want=%h", i, dout0, e0.sym); end
      total++; if ($signed(disp0) != e0.cnt) begin bad++; $display("FAIL ce_disp0 i=%0d got=%0d want=%0d", i, $signed(disp0), e0.cnt); end
      total++; if (douto !== eo.sym) begin bad++; $display("FAIL ce_douto i=%0d got=%h want=%h", i, douto, eo.sym); end
      Ce   = (i >= 10 && i < 15) ? 1'b0 : 1'b1;
      Mode = 3'b001;
      Din  = 8'(i * 37 + 5);
    end
    Ce = 1'b1;
  endtask

  task automatic test_random();
    exp_t e0, eo;
    int   d;
    for (int i = 0; i < 10000; i++) begin
      @(negedge Clk);
      e0.sym = 10'h000; e0.cnt = 0;
      eo.sym = 10'h000; eo.cnt = 0;
      if (hist.size() >= 3) e0 = hist[hist.size()-3];
      if (hist.size() >= 4) eo = hist[hist.size()-4];
      total++; if (dout0 !== e0.sym) begin bad++; $display("FAIL rnd_dout0 i=%0d got=%h want=%h", i, dout0, e0.sym); end
      total++; if ($signed(disp0) != e0.cnt) begin bad++; $display("FAIL rnd_disp0 i=%0d got=%0d want=%0d", i, $signed(disp0), e0.cnt); end
      total++; if (douto !== eo.sym) begin bad++; $display("FAIL rnd_douto i=%0d got=%h want=%h", i, douto, eo.sym); end
      total++; if ($signed(dispo) != eo.cnt) begin bad++; $display("FAIL rnd_dispo i=%0d got=%0d want=%0d", i, $signed(dispo), eo.cnt); end
      d = $signed(disp0);
      total++; if (d > 10 || d < -10) begin bad++; $display("FAIL rnd_disp_bound i=%0d got=%0d want=|d|<=10", i, d); end
      if (i == 5002) begin
        total++; if (dout0 !== 10'h354) begin bad++; $display("FAIL rst_pulse_token0 got=%h want=354", dout0); end
      end
      if (i == 5000) begin
        RstB = 1'b0;
        model_reset();
        #1;
        total++; if (dout0 !== 10'h000) begin bad++; $display("FAIL rst_pulse_dout0 got=%h want=000", dout0); end
        total++; if (douto !== 10'h000) begin bad++; $display("FAIL rst_pulse_douto got=%h want=000", douto); end
      end else if (i == 5001) begin
        RstB = 1'b1;
      end
      Ce = (i >= 4999 && i <= 5003) ? 1'b1 : ($urandom_range(0, 15) != 0);
      Mode = ($urandom_range(0, 15) < 10) ? 3'b001 : 3'($urandom_range(0, 7));
      Din  = 8'($urandom_range(0, 255));
      C0   = 1'($urandom_range(0, 1));
      C1   = 1'($urandom_range(0, 1));
      Aux  = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    RstB = 1'b0; Ce = 1'b1; Mode = 3'b000; Din = 8'h00; C0 = 1'b0; C1 = 1'b0; Aux = 4'h0;
    model_reset();
    test_reset();
    test_video_zero();
    test_terc4();
    test_guard();
    test_ce_freeze();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
